// File: rtl/branch_update_queue.sv
// Decoupling FIFO between branch resolution and the bimodal predictor's PHT update port.
// Define BRQ_STATS_EN to build the saturating branch/misprediction counters.
module branch_update_queue #(
  parameter int DEPTH = 8,
  parameter int PC_W  = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       res_valid_i,
  output logic                       res_ready_o,
  input  logic [PC_W-1:0]            res_pc_i,
  input  logic                       res_is_cond_i,
  input  logic                       res_taken_i,
  input  logic                       res_pred_taken_i,
  input  logic                       flush_i,
  input  logic                       upd_ready_i,
  output logic                       update_valid_o,
  output logic [PC_W-1:0]            update_pc_o,
  output logic                       update_taken_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic [31:0]                stat_branches_o,
  output logic [31:0]                stat_mispred_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [PC_W-1:0]  pc_mem [DEPTH];
  logic [DEPTH-1:0] taken_mem;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;

  logic full;
  logic empty;
  logic accept;
  logic enq;
  logic deq;

  // A full queue refuses input even if the head drains this cycle.
  assign full        = (count == CNT_W'(DEPTH));
  assign empty       = (count == '0);
  assign res_ready_o = !rst && !full;
  assign accept      = res_valid_i && res_ready_o;
  assign enq         = accept && res_is_cond_i;
  assign deq         = !empty && upd_ready_i;

  assign update_valid_o = !empty;
  assign update_pc_o    = empty ? '0 : pc_mem[rd_ptr];
  assign update_taken_o = !empty && taken_mem[rd_ptr];
  assign count_o        = count;

  always_ff @(posedge clk) begin
    if (enq) begin
      pc_mem[wr_ptr]    <= res_pc_i;
      taken_mem[wr_ptr] <= res_taken_i;
    end
  end

  // Flush drops undrained entries; a same-cycle dequeue was already seen by the predictor.
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (deq) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({enq, deq})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef BRQ_STATS_EN
  logic [31:0] stat_branches;
  logic [31:0] stat_mispred;

  // Counted at accept time, so flushed wrong-path branches are still included.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_branches <= '0;
      stat_mispred  <= '0;
    end else if (enq) begin
      if (stat_branches != '1) begin
        stat_branches <= stat_branches + 32'd1;
      end
      if ((res_taken_i != res_pred_taken_i) && (stat_mispred != '1)) begin
        stat_mispred <= stat_mispred + 32'd1;
      end
    end
  end

  assign stat_branches_o = stat_branches;
  assign stat_mispred_o  = stat_mispred;
`else
  logic unused_pred_taken;

  assign unused_pred_taken = res_pred_taken_i;
  assign stat_branches_o   = '0;
  assign stat_mispred_o    = '0;
`endif

endmodule

// File: tb/tb_branch_update_queue.sv
// Testbench for branch_update_queue: vector table plus scoreboard-checked drain order.
module tb_branch_update_queue;

  localparam int DEPTH = 8;
  localparam int PC_W  = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        res_valid_i;
  logic        res_ready_o;
  logic [31:0] res_pc_i;
  logic        res_is_cond_i;
  logic        res_taken_i;
  logic        res_pred_taken_i;
  logic        flush_i;
  logic        upd_ready_i;
  logic        update_valid_o;
  logic [31:0] update_pc_o;
  logic        update_taken_o;
  logic [3:0]  count_o;
  logic [31:0] stat_branches_o;
  logic [31:0] stat_mispred_o;

  int checks = 0;
  int errors = 0;
  logic mon_en = 1'b0;

  typedef struct packed {
    logic [31:0] pc;
    logic        taken;
  } entry_t;

  entry_t sb[$];

  typedef struct {
    logic        valid;
    logic [31:0] pc;
    logic        cond;
    logic        taken;
    logic        pred;
    logic        upd;
    logic        exp_ready;
    int          exp_count;
    logic        exp_uvalid;
    logic [31:0] exp_upc;
    logic        exp_utaken;
  } vec_t;

  vec_t vecs[12];

  branch_update_queue #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .clk              (clk),
    .rst              (rst),
    .res_valid_i      (res_valid_i),
    .res_ready_o      (res_ready_o),
    .res_pc_i         (res_pc_i),
    .res_is_cond_i    (res_is_cond_i),
    .res_taken_i      (res_taken_i),
    .res_pred_taken_i (res_pred_taken_i),
    .flush_i          (flush_i),
    .upd_ready_i      (upd_ready_i),
    .update_valid_o   (update_valid_o),
    .update_pc_o      (update_pc_o),
    .update_taken_o   (update_taken_o),
    .count_o          (count_o),
    .stat_branches_o  (stat_branches_o),
    .stat_mispred_o   (stat_mispred_o)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [31:0] pc, input logic cond,
                               input logic taken, input logic pred, input logic upd, input logic flush);
    res_valid_i      = valid;
    res_pc_i         = pc;
    res_is_cond_i    = cond;
    res_taken_i      = taken;
    res_pred_taken_i = pred;
    upd_ready_i      = upd;
    flush_i          = flush;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic waitEmpty(input int budget);
    int n = 0;
    while (count_o !== 4'd0 && n < budget) begin
      nextCycle();
      n++;
    end
    checkOutput("drain_within_budget", 64'(n < budget), 64'd1);
  endtask

  function automatic vec_t mk(input logic valid, input logic [31:0] pc, input logic cond,
                              input logic taken, input logic pred, input logic upd,
                              input logic exp_ready, input int exp_count, input logic exp_uvalid,
                              input logic [31:0] exp_upc, input logic exp_utaken);
    vec_t v;
    v.valid = valid; v.pc = pc; v.cond = cond; v.taken = taken; v.pred = pred; v.upd = upd;
    v.exp_ready = exp_ready; v.exp_count = exp_count; v.exp_uvalid = exp_uvalid;
    v.exp_upc = exp_upc; v.exp_utaken = exp_utaken;
    return v;
  endfunction

  // Scoreboard: compare deliveries against accepted order, and occupancy against queue size.
  always @(negedge clk) begin
    if (mon_en) begin
      checkOutput("count_vs_model", 64'(count_o), 64'(sb.size()));
      checkOutput("valid_vs_model", 64'(update_valid_o), 64'(sb.size() != 0));
      if (!update_valid_o) begin
        checkOutput("idle_pc_zero", 64'({update_pc_o, update_taken_o}), 64'd0);
      end
      if (!rst && update_valid_o && upd_ready_i) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_update", 64'(update_pc_o), 64'hDEAD);
        end else begin
          entry_t e;
          e = sb.pop_front();
          checkOutput("drain_pc", 64'(update_pc_o), 64'(e.pc));
          checkOutput("drain_taken", 64'(update_taken_o), 64'(e.taken));
        end
      end
      if (rst || flush_i) begin
        sb.delete();
      end else if (res_valid_i && res_ready_o && res_is_cond_i) begin
        sb.push_back('{pc: res_pc_i, taken: res_taken_i});
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int pushed;
    int cyc;
    logic [63:0] exp_br;
    logic [63:0] exp_mp;

    vecs[0]  = mk(1, 32'h100, 1, 1, 1, 1, 1, 0, 0, 32'h0,   0);
    vecs[1]  = mk(0, 32'h0,   0, 0, 0, 1, 1, 1, 1, 32'h100, 1);
    vecs[2]  = mk(0, 32'h0,   0, 0, 0, 1, 1, 0, 0, 32'h0,   0);
    vecs[3]  = mk(1, 32'h200, 0, 1, 0, 1, 1, 0, 0, 32'h0,   0);
    vecs[4]  = mk(0, 32'h0,   0, 0, 0, 1, 1, 0, 0, 32'h0,   0);
    vecs[5]  = mk(1, 32'h300, 1, 1, 1, 1, 1, 0, 0, 32'h0,   0);
    vecs[6]  = mk(1, 32'h304, 1, 0, 1, 1, 1, 1, 1, 32'h300, 1);
    vecs[7]  = mk(1, 32'h308, 1, 0, 0, 1, 1, 1, 1, 32'h304, 0);
    vecs[8]  = mk(1, 32'h30C, 0, 1, 0, 1, 1, 1, 1, 32'h308, 0);
    vecs[9]  = mk(1, 32'h310, 1, 1, 1, 1, 1, 0, 0, 32'h0,   0);
    vecs[10] = mk(0, 32'h0,   0, 0, 0, 1, 1, 1, 1, 32'h310, 1);
    vecs[11] = mk(0, 32'h0,   0, 0, 0, 1, 1, 0, 0, 32'h0,   0);

    rst = 1'b1;
    applyStimulus(0, 32'h0, 0, 0, 0, 0, 0);
    nextCycle();
    nextCycle();
    @(negedge clk);
    checkOutput("ready_low_in_reset", 64'(res_ready_o), 64'd0);
    nextCycle();
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_ready", 64'(res_ready_o), 64'd1);
    checkOutput("reset_count", 64'(count_o), 64'd0);
    checkOutput("reset_update", 64'({update_valid_o, update_pc_o, update_taken_o}), 64'd0);
    checkOutput("reset_stats", {stat_branches_o, stat_mispred_o}, 64'd0);
    nextCycle();
    mon_en = 1'b1;

    $display("[TB] vector table");
    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].valid, vecs[i].pc, vecs[i].cond, vecs[i].taken, vecs[i].pred, vecs[i].upd, 0);
      @(negedge clk);
      checkOutput($sformatf("vec%0d_ready", i), 64'(res_ready_o), 64'(vecs[i].exp_ready));
      checkOutput($sformatf("vec%0d_count", i), 64'(count_o), 64'(vecs[i].exp_count));
      checkOutput($sformatf("vec%0d_uvalid", i), 64'(update_valid_o), 64'(vecs[i].exp_uvalid));
      checkOutput($sformatf("vec%0d_upc", i), 64'(update_pc_o), 64'(vecs[i].exp_upc));
      checkOutput($sformatf("vec%0d_utaken", i), 64'(update_taken_o), 64'(vecs[i].exp_utaken));
      nextCycle();
    end
    applyStimulus(0, 32'h0, 0, 0, 0, 1, 0);
    @(negedge clk);
`ifdef BRQ_STATS_EN
    exp_br = 64'd5;
    exp_mp = 64'd1;
`else
    exp_br = 64'd0;
    exp_mp = 64'd0;
`endif
    checkOutput("stat_branches", 64'(stat_branches_o), exp_br);
    checkOutput("stat_mispred", 64'(stat_mispred_o), exp_mp);
    nextCycle();

    $display("[TB] fill to full, then drain");
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1, 32'h1000 + 32'(i * 4), 1, i[0], 0, 0, 0);
      @(negedge clk);
      checkOutput($sformatf("fill%0d_ready", i), 64'(res_ready_o), 64'd1);
      nextCycle();
    end
    applyStimulus(1, 32'h1FFC, 1, 1, 1, 0, 0);
    @(negedge clk);
    checkOutput("full_ready_low", 64'(res_ready_o), 64'd0);
    checkOutput("full_count", 64'(count_o), 64'd8);
    nextCycle();
    applyStimulus(1, 32'h1FFC, 1, 1, 1, 1, 0);
    @(negedge clk);
    checkOutput("full_no_bypass", 64'(res_ready_o), 64'd0);
    nextCycle();
    applyStimulus(0, 32'h0, 0, 0, 0, 1, 0);
    waitEmpty(20);

    $display("[TB] interleaved pushes with pointer wrap");
    pushed = 0;
    cyc = 0;
    while (pushed < 10 && cyc < 100) begin
      applyStimulus(1, 32'h2000 + 32'(pushed * 4), 1, pushed[0], 0, (cyc % 3) != 0, 0);
      @(negedge clk);
      if (res_ready_o) pushed++;
      nextCycle();
      cyc++;
    end
    checkOutput("wrap_all_pushed", 64'(pushed), 64'd10);
    applyStimulus(0, 32'h0, 0, 0, 0, 1, 0);
    waitEmpty(20);

    $display("[TB] flush with same-cycle accept");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 32'h3000 + 32'(i * 4), 1, 1, 0, 0, 0);
      nextCycle();
    end
    applyStimulus(1, 32'h3FFC, 1, 1, 0, 0, 1);
    @(negedge clk);
    checkOutput("flush_ready_high", 64'(res_ready_o), 64'd1);
    nextCycle();
    applyStimulus(0, 32'h0, 0, 0, 0, 1, 0);
    @(negedge clk);
    checkOutput("flush_count", 64'(count_o), 64'd0);
    checkOutput("flush_uvalid", 64'(update_valid_o), 64'd0);
    for (int i = 0; i < 4; i++) nextCycle();

    $display("[TB] non-conditional handshake");
    applyStimulus(1, 32'h4000, 0, 1, 0, 1, 0);
    @(negedge clk);
    checkOutput("noncond_ready", 64'(res_ready_o), 64'd1);
    nextCycle();
    applyStimulus(0, 32'h0, 0, 0, 0, 1, 0);
    @(negedge clk);
    checkOutput("noncond_count", 64'(count_o), 64'd0);
    checkOutput("noncond_no_update", 64'(update_valid_o), 64'd0);
    nextCycle();

    $display("[TB] reset mid-drain");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 32'h5000 + 32'(i * 4), 1, 0, 0, 0, 0);
      nextCycle();
    end
    applyStimulus(0, 32'h0, 0, 0, 0, 1, 0);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midreset_ready_low", 64'(res_ready_o), 64'd0);
    nextCycle();
    rst = 1'b0;
    @(negedge clk);
    checkOutput("midreset_count", 64'(count_o), 64'd0);
    checkOutput("midreset_update", 64'({update_valid_o, update_pc_o, update_taken_o}), 64'd0);
    checkOutput("midreset_ready", 64'(res_ready_o), 64'd1);
    checkOutput("midreset_stats", {stat_branches_o, stat_mispred_o}, 64'd0);
    for (int i = 0; i < 3; i++) nextCycle();

    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_update_queue.md
# branch_update_queue

Decoupling FIFO between execute-stage branch resolution and the bimodal predictor's training port. It accepts resolved conditional branches through a valid/ready handshake and buffers up to DEPTH of them. It drains them in order to the predictor update interface (update_valid/update_pc/update_taken) whenever the PHT write port is available. A flush discards wrong-path entries that have not yet been drained.

## Interface
- DEPTH, 8: queue entries; power of two, ≥2
- PC_W, 32: PC width

- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- res_valid_i  in  1  resolved branch offered by execute
- res_ready_o  out  1  queue can accept this cycle
- res_pc_i  in  PC_W  branch PC
- res_is_cond_i  in  1  conditional branch; only these train the PHT
- res_taken_i  in  1  actual outcome
- res_pred_taken_i  in  1  outcome predicted at fetch
- flush_i  in  1  pipeline flush; drop all queued entries
- upd_ready_i  in  1  predictor PHT write port free this cycle
- update_valid_o  out  1  to predictor update_valid_i
- update_pc_o  out  PC_W  to predictor update_pc_i
- update_taken_o  out  1  to predictor update_taken_i
- count_o  out  $clog2(DEPTH+1)  current occupancy
- stat_branches_o  out  32  accepted conditional branches (stats build)
- stat_mispred_o  out  32  accepted conditional mispredictions (stats build)

## Operation
- Circular buffer with rd_ptr/wr_ptr of $clog2(DEPTH) bits that wrap naturally, plus a separate count register (0..DEPTH).
- Accept: a cycle where res_valid_i && res_ready_o. If res_is_cond_i=1, {pc, taken} is written at wr_ptr and wr_ptr increments. If res_is_cond_i=0, the handshake completes and nothing is written.
- res_ready_o = !rst && (count != DEPTH). At count==DEPTH, input is refused even when a dequeue happens in the same cycle. There is no full-bypass.
- Drain: when count!=0, update_valid_o=1 and update_pc_o/update_taken_o present the head entry. Dequeue happens when update_valid_o && upd_ready_i, and rd_ptr increments.
- While upd_ready_i=0, the head entry and all outputs hold steady.
- When empty: update_valid_o=0, update_pc_o=0, update_taken_o=0.
- Enqueue and dequeue in the same cycle: count unchanged, both pointers advance.
- Order is strict FIFO. No coalescing of equal PCs: each resolution trains the PHT once.
- flush_i=1: next cycle count=0 and rd_ptr=wr_ptr=0. A same-cycle accepted input is discarded. A same-cycle dequeue still counts as delivered, because the predictor samples it that cycle.
- flush_i does not deassert res_ready_o.

## Timing
- Outputs come from flops; there is no combinational path from res_* to update_*.
- Enqueue-to-update latency: an entry accepted in cycle N is visible on update_valid_o in cycle N+1 if the queue was empty. Otherwise it appears after all older entries.
- Throughput: 1 accept and 1 drain per cycle.
- count_o is registered and reflects all events of the previous cycle.
- Reset (rst high at a clk edge) clears pointers, count and stats from the following cycle:
  - update_valid_o=0, update_pc_o=0, update_taken_o=0, count_o=0, stat_*=0.
  - res_ready_o=0 while rst is high, and 1 in the first cycle after.
- Reset asserted mid-drain drops all contents with no partial update.

## Configuration
- BRQ_STATS_EN defined:
  - stat_branches_o increments on every accepted conditional resolution.
  - stat_mispred_o increments when, in addition, res_taken_i != res_pred_taken_i.
  - Both counters saturate at 32'hFFFF_FFFF.
  - Both count at accept time, whether or not a flush occurs that cycle.
- Not defined: both stat ports are tied to 0, no counter flops are built, and all other behaviour is identical.

## Test plan
- Reset, then upd_ready_i=1 and one cond branch pc=0x100, taken=1 in cycle N -> update_valid_o=1, update_pc_o=0x100, update_taken_o=1 in cycle N+1 only; count_o returns to 0.
- upd_ready_i=0, push 8 cond branches (DEPTH=8) -> res_ready_o=0 at count 8 and a 9th offer is not accepted. Then raise upd_ready_i -> the 8 PCs drain in order, one per cycle.
- Push 10 entries over time, interleaved with drains (pointer wrap) -> output order matches input order exactly, and count_o never exceeds 8.
- 3 queued entries, flush_i plus a new accept in the same cycle -> next cycle count_o=0 and update_valid_o=0, and the new entry never appears.
- Offer res_is_cond_i=0 -> handshake completes, count_o unchanged, no update issued.
- With BRQ_STATS_EN: 4 cond accepts with 1 mismatch plus 1 non-cond accept -> stat_branches_o=4, stat_mispred_o=1. Without the macro, both read 0.
